// File: rtl/dtree_pkg.sv
// Shared types and constants for the dtree classifier scheduler.
package dtree_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StWait,
    StHold
  } state_e;

  localparam int unsigned DefChannels = 4;
  localparam int unsigned DefFeatures = 3;

  localparam int unsigned CH_W  = $clog2(DefChannels);
  localparam int unsigned LVL_W = $clog2(DefFeatures);

  // Next round-robin position, wrapping n-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, searching upward
// and wrapping.
module rr_arbiter #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic [NumReq-1:0]         gnt_o,
  output logic [$clog2(NumReq)-1:0] idx_o,
  output logic                      valid_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  int               cand;
  logic [IdxW-1:0]  cand_idx;
  logic             found;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      cand     = (int'(ptr_i) + k) % int'(NumReq);
      cand_idx = IdxW'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/dtree_scheduler.sv
// Time-shares one dtree classifier between several channels: round-robin grant, feature
// streaming, bounded wait for the result, and a valid/ready result handoff.
module dtree_scheduler
  import dtree_pkg::*;
#(
  parameter int unsigned CHANNELS = DefChannels,
  parameter int unsigned FEATURES = DefFeatures,
  parameter int unsigned IN_WIDTH = 10,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         req,
  input  logic [IN_WIDTH-1:0]         feat_data,
  output logic [CHANNELS-1:0]         grant,
  output logic [$clog2(FEATURES)-1:0] feat_idx,
  output logic [CHANNELS-1:0]         done,
  output logic                        dtree_start,
  output logic [IN_WIDTH-1:0]         dtree_sample,
  input  logic [$clog2(FEATURES)-1:0] dtree_level,
  input  logic [$clog2(FEATURES)-1:0] dtree_path,
  input  logic                        dtree_valid,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [$clog2(CHANNELS)-1:0] res_channel,
  output logic [$clog2(FEATURES)-1:0] res_level,
  output logic [$clog2(FEATURES)-1:0] res_path,
  output logic                        res_timeout
);

  localparam int unsigned ChW  = $clog2(CHANNELS);
  localparam int unsigned LvlW = $clog2(FEATURES);
  localparam int unsigned CntW = $clog2(MAX_WAIT);

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [LvlW-1:0]     feat_idx_q, feat_idx_d;
  logic [ChW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]     wait_cnt_q, wait_cnt_d;
  logic                res_valid_q, res_valid_d;
  logic [ChW-1:0]      res_channel_q, res_channel_d;
  logic [LvlW-1:0]     res_level_q, res_level_d;
  logic [LvlW-1:0]     res_path_q, res_path_d;
  logic                res_timeout_q, res_timeout_d;

  logic [CHANNELS-1:0] arb_gnt;
  logic [ChW-1:0]      arb_idx;
  logic                arb_valid;

  rr_arbiter #(
    .NumReq (CHANNELS)
  ) u_rr_arbiter (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    feat_idx_d    = feat_idx_q;
    rr_ptr_d      = rr_ptr_q;
    wait_cnt_d    = wait_cnt_q;
    res_valid_d   = res_valid_q;
    res_channel_d = res_channel_q;
    res_level_d   = res_level_q;
    res_path_d    = res_path_q;
    res_timeout_d = res_timeout_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d       = arb_gnt;
          res_channel_d = arb_idx;
          feat_idx_d    = '0;
          state_d       = StFeed;
        end
      end
      StFeed: begin
        if (feat_idx_q == LvlW'(FEATURES - 1)) begin
          feat_idx_d = '0;
          wait_cnt_d = '0;
          state_d    = StWait;
        end else begin
          feat_idx_d = feat_idx_q + 1'b1;
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        // A valid landing on the last allowed cycle still beats the timeout.
        if (dtree_valid) begin
          res_level_d   = dtree_level;
          res_path_d    = dtree_path;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = StHold;
        end else if (wait_cnt_q == CntW'(MAX_WAIT - 1)) begin
          res_level_d   = '0;
          res_path_d    = '0;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = StHold;
        end
      end
      StHold: begin
        if (res_ready) begin
          grant_d     = '0;
          res_valid_d = 1'b0;
          rr_ptr_d    = ChW'(wrap_inc(32'(res_channel_q), CHANNELS));
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      feat_idx_q    <= '0;
      rr_ptr_q      <= '0;
      wait_cnt_q    <= '0;
      res_valid_q   <= 1'b0;
      res_channel_q <= '0;
      res_level_q   <= '0;
      res_path_q    <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      feat_idx_q    <= feat_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      wait_cnt_q    <= wait_cnt_d;
      res_valid_q   <= res_valid_d;
      res_channel_q <= res_channel_d;
      res_level_q   <= res_level_d;
      res_path_q    <= res_path_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  // Feature path is decoded from registered state so reset clears it immediately.
  assign grant        = grant_q;
  assign feat_idx     = feat_idx_q;
  assign dtree_start  = (state_q == StFeed) && (feat_idx_q == '0);
  assign dtree_sample = (state_q == StFeed) ? feat_data : '0;
  assign done         = (state_q == StHold && res_ready) ? grant_q : '0;
  assign res_valid    = res_valid_q;
  assign res_channel  = res_channel_q;
  assign res_level    = res_level_q;
  assign res_path     = res_path_q;
  assign res_timeout  = res_timeout_q;

endmodule

// File: tb/tb_dtree_scheduler.sv
// Self-checking bench for dtree_scheduler with a channel-buffer model, a classifier model
// and a result scoreboard.
module tb_dtree_scheduler;
  import dtree_pkg::*;

  localparam int unsigned Ch      = 4;
  localparam int unsigned Feat    = 3;
  localparam int unsigned InW     = 10;
  localparam int unsigned MaxWait = 16;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [LVL_W-1:0] lvl;
    logic [LVL_W-1:0] path;
    logic             to;
  } res_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [Ch-1:0]    req;
  logic [InW-1:0]   feat_data;
  logic [Ch-1:0]    grant;
  logic [LVL_W-1:0] feat_idx;
  logic [Ch-1:0]    done;
  logic             dtree_start;
  logic [InW-1:0]   dtree_sample;
  logic [LVL_W-1:0] dtree_level = '0;
  logic [LVL_W-1:0] dtree_path = '0;
  logic             dtree_valid = 1'b0;
  logic             res_valid;
  logic             res_ready;
  logic [CH_W-1:0]  res_channel;
  logic [LVL_W-1:0] res_level;
  logic [LVL_W-1:0] res_path;
  logic             res_timeout;

  int n_cmp = 0;
  int n_err = 0;
  res_t sb[$];
  res_t act;
  logic [63:0] all_out;

  int               mcnt = -1;
  int               model_delay = -1;
  bit               model_stale = 1'b0;
  logic [LVL_W-1:0] model_level = '0;
  logic [LVL_W-1:0] model_path = '0;
  int               done_cnt[Ch];

  dtree_scheduler #(
    .CHANNELS (Ch),
    .FEATURES (Feat),
    .IN_WIDTH (InW),
    .MAX_WAIT (MaxWait)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .feat_data    (feat_data),
    .grant        (grant),
    .feat_idx     (feat_idx),
    .done         (done),
    .dtree_start  (dtree_start),
    .dtree_sample (dtree_sample),
    .dtree_level  (dtree_level),
    .dtree_path   (dtree_path),
    .dtree_valid  (dtree_valid),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_channel  (res_channel),
    .res_level    (res_level),
    .res_path     (res_path),
    .res_timeout  (res_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [InW-1:0] sample_of(input int ch, input int idx);
    return InW'(ch * 64 + idx * 3 + 7);
  endfunction

  // Channel buffers: combinational read of the granted channel's sample.
  always_comb begin
    feat_data = '0;
    for (int i = 0; i < int'(Ch); i++) begin
      if (grant[i]) feat_data = sample_of(i, int'(feat_idx));
    end
  end

  assign act     = {res_channel, res_level, res_path, res_timeout};
  assign all_out = 64'({grant, feat_idx, done, dtree_start, dtree_sample, res_valid,
                        res_channel, res_level, res_path, res_timeout});

  // Classifier model: valid model_delay cycles into WAIT, optional stale valid mid-FEED.
  always @(negedge clk) begin
    if (!reset) begin
      mcnt        = -1;
      dtree_valid = 1'b0;
    end else begin
      if (dtree_start) mcnt = 0;
      else if (mcnt >= 0) mcnt++;
      if (model_delay >= 0 && mcnt == int'(Feat) + model_delay) begin
        dtree_valid = 1'b1;
        dtree_level = model_level;
        dtree_path  = model_path;
      end else if (model_stale && mcnt == 1) begin
        dtree_valid = 1'b1;
        dtree_level = '1;
        dtree_path  = '1;
      end else begin
        dtree_valid = 1'b0;
        dtree_level = '0;
        dtree_path  = '0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < int'(Ch); i++) if (done[i] === 1'b1) done_cnt[i]++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset       = 1'b0;
    req         = '0;
    res_ready   = 1'b0;
    model_delay = -1;
    model_stale = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic wait_res(input int max_cyc, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < max_cyc) begin
      if (res_valid === 1'b1) ok = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (all_out !== 64'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, need 0", all_out);
    end
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (grant !== '0 || res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_req: grant=%b res_valid=%b, need 0000/0", grant, res_valid);
    end
  endtask

  task automatic test_single();
    res_t e;
    int cyc, d0;
    bit ok;
    apply_reset();
    d0 = done_cnt[0];
    model_delay = 4; model_level = 2'd1; model_path = 2'd2; model_stale = 1'b1;
    res_ready = 1'b1;
    req = 4'b0001;
    sb.push_back('{ch: 2'd0, lvl: 2'd1, path: 2'd2, to: 1'b0});
    tick();
    req = '0;
    for (int i = 0; i < int'(Feat); i++) begin
      n_cmp++;
      if (grant !== 4'b0001 || feat_idx !== LVL_W'(i) || dtree_start !== 1'(i == 0) ||
          dtree_sample !== sample_of(0, i)) begin
        n_err++;
        $display("FAIL single_feed[%0d]: grant=%b idx=%0d start=%b sample=%0d, need 0001/%0d/%b/%0d",
                 i, grant, feat_idx, dtree_start, dtree_sample, i, (i == 0), sample_of(0, i));
      end
      tick();
    end
    n_cmp++;
    if (dtree_sample !== '0 || dtree_start !== 1'b0) begin
      n_err++;
      $display("FAIL single_wait_sample: sample=%0d start=%b, need 0/0", dtree_sample, dtree_start);
    end
    wait_res(40, cyc, ok);
    n_cmp++;
    if (!ok || cyc != 5) begin
      n_err++;
      $display("FAIL single_latency: ok=%b cycles=%0d, need 1/5", ok, cyc);
    end
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    n_cmp++;
    if (act !== e || done !== 4'b0001) begin
      n_err++;
      $display("FAIL single_result: res=%h done=%b, need %h/0001", act, done, e);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b0 || grant !== '0 || done !== '0) begin
      n_err++;
      $display("FAIL single_release: valid=%b grant=%b done=%b, need 0", res_valid, grant, done);
    end
    repeat (3) tick();
    n_cmp++;
    if (done_cnt[0] - d0 != 1) begin
      n_err++;
      $display("FAIL single_done_count: got %0d, need 1", done_cnt[0] - d0);
    end
  endtask

  task automatic test_fairness();
    res_t e;
    int cyc;
    bit ok;
    apply_reset();
    res_ready = 1'b1; model_delay = 2;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      model_level = LVL_W'(n % 4);
      model_path  = LVL_W'((n + 1) % 4);
      sb.push_back('{ch: CH_W'(n % 4), lvl: LVL_W'(n % 4), path: LVL_W'((n + 1) % 4), to: 1'b0});
      wait_res(60, cyc, ok);
      if (n == 4) req = '0;
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      n_cmp++;
      if (!ok || grant !== 4'(1 << (n % 4)) || act !== e || done !== 4'(1 << (n % 4))) begin
        n_err++;
        $display("FAIL fair[%0d]: ok=%b grant=%b res=%h done=%b, need grant=%b res=%h",
                 n, ok, grant, act, done, 4'(1 << (n % 4)), e);
      end
      tick();
      n_cmp++;
      if (grant !== '0 || res_valid !== 1'b0) begin
        n_err++;
        $display("FAIL fair_gap[%0d]: grant=%b valid=%b, need 0000/0", n, grant, res_valid);
      end
    end
  endtask

  task automatic test_timeout(input bit late_valid);
    res_t e;
    int cyc;
    bit ok;
    logic [Ch-1:0] g;
    apply_reset();
    res_ready = 1'b1;
    if (late_valid) begin
      model_delay = int'(MaxWait) - 1; model_level = 2'd2; model_path = 2'd1;
      g = 4'b0100;
      sb.push_back('{ch: 2'd2, lvl: 2'd2, path: 2'd1, to: 1'b0});
    end else begin
      model_delay = -1;
      g = 4'b0010;
      sb.push_back('{ch: 2'd1, lvl: 2'd0, path: 2'd0, to: 1'b1});
    end
    req = g;
    tick();
    req = '0;
    n_cmp++;
    if (grant !== g) begin
      n_err++;
      $display("FAIL tmo_grant[%0d]: got %b, need %b", late_valid, grant, g);
    end
    repeat (Feat) tick();
    wait_res(40, cyc, ok);
    n_cmp++;
    if (!ok || cyc != int'(MaxWait)) begin
      n_err++;
      $display("FAIL tmo_latency[%0d]: ok=%b cycles=%0d, need 1/%0d", late_valid, ok, cyc, MaxWait);
    end
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    n_cmp++;
    if (act !== e || done !== g) begin
      n_err++;
      $display("FAIL tmo_result[%0d]: res=%h done=%b, need %h/%b", late_valid, act, done, e, g);
    end
    tick();
  endtask

  task automatic test_backpressure();
    res_t e;
    int cyc, d3;
    bit ok;
    apply_reset();
    d3 = done_cnt[3];
    model_delay = 3; model_level = 2'd3; model_path = 2'd0;
    req = 4'b1000;
    sb.push_back('{ch: 2'd3, lvl: 2'd3, path: 2'd0, to: 1'b0});
    tick();
    tick();
    req = '0;
    tick();
    tick();
    wait_res(40, cyc, ok);
    n_cmp++;
    if (!ok || cyc != 4) begin
      n_err++;
      $display("FAIL bp_latency: ok=%b cycles=%0d, need 1/4", ok, cyc);
    end
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (act !== e || res_valid !== 1'b1 || done !== '0 || grant !== 4'b1000) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: res=%h valid=%b done=%b grant=%b, need %h/1/0000/1000",
                 i, act, res_valid, done, grant, e);
      end
      tick();
    end
    res_ready = 1'b1;
    #1;
    n_cmp++;
    if (done !== 4'b1000) begin
      n_err++;
      $display("FAIL bp_done: got %b, need 1000", done);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b0 || grant !== '0) begin
      n_err++;
      $display("FAIL bp_release: valid=%b grant=%b, need 0/0000", res_valid, grant);
    end
    repeat (3) tick();
    n_cmp++;
    if (done_cnt[3] - d3 != 1 || grant !== '0) begin
      n_err++;
      $display("FAIL bp_done_count: got %0d grant=%b, need 1/0000", done_cnt[3] - d3, grant);
    end
  endtask

  task automatic test_reset_mid_feed();
    res_t e;
    int cyc, d0;
    bit ok;
    apply_reset();
    d0 = done_cnt[0];
    res_ready = 1'b1; model_delay = 2; model_level = 2'd1; model_path = 2'd1;
    req = 4'b0001;
    tick();
    tick();
    n_cmp++;
    if (feat_idx !== 2'd1) begin
      n_err++;
      $display("FAIL rst_pre_idx: got %0d, need 1", feat_idx);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (all_out !== 64'd0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %h, need 0", all_out);
    end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (grant !== 4'b0001 || feat_idx !== '0 || dtree_start !== 1'b1) begin
      n_err++;
      $display("FAIL rst_regrant: grant=%b idx=%0d start=%b, need 0001/0/1",
               grant, feat_idx, dtree_start);
    end
    req = '0;
    sb.push_back('{ch: 2'd0, lvl: 2'd1, path: 2'd1, to: 1'b0});
    wait_res(40, cyc, ok);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    n_cmp++;
    if (!ok || act !== e || done !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_result: ok=%b res=%h done=%b, need 1/%h/0001", ok, act, done, e);
    end
    repeat (3) tick();
    n_cmp++;
    if (done_cnt[0] - d0 != 1) begin
      n_err++;
      $display("FAIL rst_done_count: got %0d, need 1", done_cnt[0] - d0);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(Ch); i++) done_cnt[i] = 0;
    reset     = 1'b0;
    req       = '0;
    res_ready = 1'b0;
    repeat (2) tick();
    test_reset();
    test_single();
    test_fairness();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_backpressure();
    test_reset_mid_feed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
    $fatal(1);
  end

endmodule
